// File: rtl/jtpopeye_objram.sv
// Popeye object RAM shared between the CPU and the sprite DMA engine.
// A Z80-style busrq/busak handshake hands the RAM to the DMA once the CPU access closes.
module jtpopeye_objram #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cen,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    input  logic          cpu_cs,
    input  logic          cpu_wr_n,
    output logic          cpu_hold,
    input  logic          busrq_n,
    output logic          busak_n,
    input  logic [AW-1:0] dma_addr,
    input  logic          dma_cs,
    output logic [DW-1:0] dma_dout,
    output logic          dma_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CPU = 2'd1,
        GRANT    = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t state, next_state;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          cpu_we;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Arbitration only advances on CPU clock-enable edges.
    always_comb begin
        next_state = state;
        if (cpu_cen) begin
            case (state)
                IDLE: begin
                    if (!busrq_n) next_state = cpu_cs ? WAIT_CPU : GRANT;
                end
                WAIT_CPU: begin
                    if (busrq_n)      next_state = IDLE;
                    else if (!cpu_cs) next_state = GRANT;
                end
                GRANT: begin
                    if (busrq_n) next_state = RELEASE;
                end
                RELEASE: next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        busak_n  = (state != GRANT);
        cpu_hold = (state == GRANT) || (state == RELEASE);
        // Writes are refused while the DMA owns or is handing back the bus.
        cpu_we   = cpu_cen && cpu_cs && !cpu_wr_n && !rst &&
                   ((state == IDLE) || (state == WAIT_CPU));
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (cpu_we) mem[cpu_addr] <= cpu_din;
    end

    always_ff @(posedge clk) begin
        if (rst)                            cpu_dout <= '1;
        else if (cpu_cs && state != GRANT)  cpu_dout <= mem[cpu_addr];
    end

    // DMA reads are per clk, independent of cpu_cen; a strobe without grant is flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_dout <= '1;
            dma_err  <= 1'b0;
        end else if (dma_cs) begin
            if (state == GRANT) begin
                dma_dout <= mem[dma_addr];
            end else begin
                dma_dout <= '1;
                dma_err  <= 1'b1;
            end
        end
    end

endmodule
